// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core encodings for the writeback stage
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RESULT_ALU = 2'd0;
  localparam logic [1:0] RESULT_MEM = 2'd1;
  localparam logic [1:0] RESULT_PC4 = 2'd2;
  localparam logic [1:0] RESULT_IMM = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load byte/halfword/word extraction, extension and alignment check
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN_P = core_pkg::XLEN
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN_P-1:0] rdata,
  output logic [XLEN_P-1:0] data,
  output logic              misaligned,
  output logic              illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN_P-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN_P-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(XLEN_P-16){half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(XLEN_P-16){1'b0}}, half_sel};
        misaligned = addr_lo[0];
      end
      F3_LW: begin
        data       = rdata;
        misaligned = (addr_lo != 2'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, writeback mux and retire counter
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic             mem_stall,
  input  logic             mem_flush,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_result_src,
  input  logic [2:0]       mem_funct3,
  input  logic [1:0]       mem_addr_lo,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic [XLEN-1:0]  mem_imm,
  output logic             RegWrite,
  output logic [4:0]       Rd,
  output logic [XLEN-1:0]  Write_data,
  output logic             wb_valid,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q;
  logic             reg_write_q;
  logic [4:0]       rd_q;
  logic [1:0]       src_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  rdata_q;
  logic [XLEN-1:0]  pc4_q;
  logic [XLEN-1:0]  imm_q;
  logic [CNT_W-1:0] instret_q;

  // Flush beats stall; the instruction leaving WB retires whenever it is replaced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      src_q       <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      instret_q   <= '0;
    end else if (mem_flush || !mem_stall) begin
      if (valid_q) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (mem_flush) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        rd_q        <= '0;
        src_q       <= '0;
        funct3_q    <= '0;
        addr_lo_q   <= '0;
        alu_q       <= '0;
        rdata_q     <= '0;
        pc4_q       <= '0;
        imm_q       <= '0;
      end else begin
        valid_q     <= mem_valid;
        reg_write_q <= mem_reg_write;
        rd_q        <= mem_rd;
        src_q       <= mem_result_src;
        funct3_q    <= mem_funct3;
        addr_lo_q   <= mem_addr_lo;
        alu_q       <= mem_alu_result;
        rdata_q     <= mem_rdata;
        pc4_q       <= mem_pc_plus4;
        imm_q       <= mem_imm;
      end
    end
  end

  logic [XLEN-1:0] load_data;
  logic            load_mis;
  logic            load_illegal;

  load_extend #(.XLEN_P(XLEN)) u_load_extend (
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .rdata      (rdata_q),
    .data       (load_data),
    .misaligned (load_mis),
    .illegal    (load_illegal)
  );

  logic            is_load;
  logic            misaligned;
  logic            we;
  logic [XLEN-1:0] result;

  always_comb begin
    result = '0;
    case (src_q)
      RESULT_ALU: result = alu_q;
      RESULT_MEM: result = load_data;
      RESULT_PC4: result = pc4_q;
      RESULT_IMM: result = imm_q;
      default:    result = '0;
    endcase
  end

  assign is_load    = valid_q && (src_q == RESULT_MEM);
  assign misaligned = is_load && load_mis;
  // Unknown load widths are dropped silently rather than writing garbage.
  assign we = valid_q && reg_write_q && (rd_q != 5'd0) && !misaligned
              && !(is_load && load_illegal);

  assign RegWrite        = we;
  assign Rd              = we ? rd_q : 5'd0;
  assign Write_data      = we ? result : '0;
  assign wb_valid        = valid_q;
  assign load_misaligned = misaligned;
  assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a behavioural model
module tb_wb_stage;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  ins_t cur   = '0;

  logic        reg_write, reg_write_s;
  logic [4:0]  rd, rd_s;
  logic [31:0] wdata, wdata_s;
  logic        wbv, wbv_s;
  logic        mis, mis_s;
  logic [63:0] instret;
  logic [3:0]  instret_s;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset(rst_n), .mem_valid(cur.v), .mem_stall(stall), .mem_flush(flush),
    .mem_reg_write(cur.rw), .mem_rd(cur.rd), .mem_result_src(cur.src), .mem_funct3(cur.f3),
    .mem_addr_lo(cur.lo), .mem_alu_result(cur.alu), .mem_rdata(cur.rdata),
    .mem_pc_plus4(cur.pc4), .mem_imm(cur.imm),
    .RegWrite(reg_write), .Rd(rd), .Write_data(wdata), .wb_valid(wbv),
    .load_misaligned(mis), .instret(instret)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .reset(rst_n), .mem_valid(cur.v), .mem_stall(stall), .mem_flush(flush),
    .mem_reg_write(cur.rw), .mem_rd(cur.rd), .mem_result_src(cur.src), .mem_funct3(cur.f3),
    .mem_addr_lo(cur.lo), .mem_alu_result(cur.alu), .mem_rdata(cur.rdata),
    .mem_pc_plus4(cur.pc4), .mem_imm(cur.imm),
    .RegWrite(reg_write_s), .Rd(rd_s), .Write_data(wdata_s), .wb_valid(wbv_s),
    .load_misaligned(mis_s), .instret(instret_s)
  );

  int passed = 0;
  int total  = 0;

  ins_t        wb_m;
  longint unsigned retired = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * lo);
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return sh & 32'hFF;
      3'b001, 3'b101: begin
        sh = w >> (16 * (lo / 2));
        return (f3 == 3'b001) ? 32'($signed(sh[15:0])) : (sh & 32'hFFFF);
      end
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_misaligned(input ins_t m);
    if (!m.v || m.src != 2'd1) return 1'b0;
    if (m.f3 == 3'b001 || m.f3 == 3'b101) return (m.lo % 2) != 0;
    if (m.f3 == 3'b010) return m.lo != 0;
    return 1'b0;
  endfunction

  function automatic bit is_legal_load(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  task automatic check_outputs();
    bit          exp_we;
    logic [31:0] val;
    case (wb_m.src)
      2'd0: val = wb_m.alu;
      2'd1: val = load_value(wb_m.f3, wb_m.lo, wb_m.rdata);
      2'd2: val = wb_m.pc4;
      default: val = wb_m.imm;
    endcase
    exp_we = wb_m.v && wb_m.rw && wb_m.rd != 0 && !is_misaligned(wb_m)
             && !(wb_m.src == 2'd1 && !is_legal_load(wb_m.f3));
    chk("wb_valid", 64'(wbv), 64'(wb_m.v));
    chk("RegWrite", 64'(reg_write), 64'(exp_we));
    chk("Rd", 64'(rd), exp_we ? 64'(wb_m.rd) : 64'd0);
    chk("Write_data", 64'(wdata), exp_we ? 64'(val) : 64'd0);
    chk("load_misaligned", 64'(mis), 64'(is_misaligned(wb_m)));
    chk("instret", instret, retired);
    chk("instret_w4", 64'(instret_s), retired % 16);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      wb_m    = '0;
      retired = 0;
    end else if (flush || !stall) begin
      if (wb_m.v) retired++;
      wb_m = flush ? '0 : cur;
    end
    #1;
    check_outputs();
  endtask

  function automatic ins_t mk(input logic [4:0] rdv, input logic [1:0] src, input logic [2:0] f3,
                              input logic [1:0] lo, input logic [31:0] data);
    ins_t t;
    t = '0;
    t.v = 1'b1; t.rw = 1'b1; t.rd = rdv; t.src = src; t.f3 = f3; t.lo = lo;
    t.alu = data; t.rdata = data; t.pc4 = data; t.imm = data;
    return t;
  endfunction

  initial begin
    // reset held with a live instruction on the inputs
    cur = mk(5'd9, 2'd0, 3'b000, 2'd0, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    step();
    step();
    chk("reset_regwrite", 64'(reg_write), 64'd0);
    chk("reset_instret", instret, 64'd0);
    rst_n = 1'b1;

    cur = mk(5'd5, 2'd0, 3'b000, 2'd0, 32'h0000_1234);
    step();
    chk("alu_rd", 64'(rd), 64'd5);
    chk("alu_data", 64'(wdata), 64'h1234);
    chk("alu_instret_pre", instret, 64'd0);
    cur = '0;
    step();
    chk("alu_instret_post", instret, 64'd1);

    cur = mk(5'd3, 2'd1, 3'b000, 2'd0, 32'h80F1_7F82); step();
    chk("lb0", 64'(wdata), 64'hFFFF_FF82);
    cur = mk(5'd3, 2'd1, 3'b100, 2'd3, 32'h80F1_7F82); step();
    chk("lbu3", 64'(wdata), 64'h0000_0080);
    cur = mk(5'd3, 2'd1, 3'b001, 2'd2, 32'h80F1_7F82); step();
    chk("lh2", 64'(wdata), 64'hFFFF_80F1);
    cur = mk(5'd3, 2'd1, 3'b101, 2'd0, 32'h80F1_7F82); step();
    chk("lhu0", 64'(wdata), 64'h0000_7F82);
    cur = mk(5'd3, 2'd1, 3'b010, 2'd0, 32'h80F1_7F82); step();
    chk("lw", 64'(wdata), 64'h80F1_7F82);

    cur = mk(5'd7, 2'd1, 3'b010, 2'd1, 32'h80F1_7F82); step();
    chk("lw_mis_flag", 64'(mis), 64'd1);
    chk("lw_mis_we", 64'(reg_write), 64'd0);
    cur = mk(5'd7, 2'd1, 3'b001, 2'd1, 32'h80F1_7F82); step();
    chk("lh_mis_flag", 64'(mis), 64'd1);
    cur = '0; step();
    chk("mis_pulse_end", 64'(mis), 64'd0);

    cur = mk(5'd0, 2'd0, 3'b000, 2'd0, 32'hFFFF_FFFF); step();
    chk("x0_we", 64'(reg_write), 64'd0);
    chk("x0_data", 64'(wdata), 64'd0);

    cur = mk(5'd1, 2'd2, 3'b000, 2'd0, 32'h0000_0104); step();
    stall = 1'b1;
    cur = mk(5'd2, 2'd0, 3'b000, 2'd0, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rd", 64'(rd), 64'd1);
      chk("stall_data", 64'(wdata), 64'h104);
    end
    stall = 1'b0; cur = '0; step();
    chk("stall_count", 64'(retired), 64'(instret));

    cur = mk(5'd4, 2'd3, 3'b000, 2'd0, 32'hABCD_0000); step();
    stall = 1'b1; step();
    flush = 1'b1; step();
    chk("flush_valid", 64'(wbv), 64'd0);
    chk("flush_we", 64'(reg_write), 64'd0);
    stall = 1'b0; flush = 1'b0;

    for (int n = 0; n < 400; n++) begin
      cur       = ins_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      cur.v     = ($urandom_range(0, 7) != 0);
      cur.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
